// File: rtl/cache_nwsa_ctrl.sv
// cache_nwsa_ctrl
//   N-way set-associative, write-back, write-allocate cache controller that
//   sits between a CPU and word-addressed main memory. Tag, data, valid,
//   dirty and LRU state live in internal flops. Only one CPU request is in
//   flight at a time.
//
// Ports
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   addr_cpu, rd_cpu, wr_cpu,       CPU request (held until ack_cpu); rd+wr together = write
//   wdata_cpu
//   rdata_cpu, ack_cpu, stall_cpu   CPU response: one-cycle ack, data valid with ack
//   addr_mem, rd_mem, wr_mem,       memory burst side: refill (rd_mem) or writeback (wr_mem),
//   wdata_mem, rdata_mem, ready_mem one beat per cycle with ready_mem=1
//   hit_cnt, miss_cnt               saturating lookup statistics
module cache_nwsa_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_cpu,
    input  logic              rd_cpu,
    input  logic              wr_cpu,
    input  logic [DATA_W-1:0] wdata_cpu,
    output logic [DATA_W-1:0] rdata_cpu,
    output logic              ack_cpu,
    output logic              stall_cpu,
    output logic [ADDR_W-1:0] addr_mem,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [DATA_W-1:0] wdata_mem,
    input  logic [DATA_W-1:0] rdata_mem,
    input  logic              ready_mem,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int OW  = $clog2(LINE_WORDS);
    localparam int IW  = $clog2(SETS);
    localparam int TW  = ADDR_W - OW - IW;
    localparam int OWB = (OW > 0) ? OW : 1;
    localparam int IWB = (IW > 0) ? IW : 1;
    localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    // DONE is the single response cycle: the line update (write merge,
    // read capture) happens there and ack_cpu rises on the edge leaving it.
    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                req_wr_q, req_wr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [AW-1:0]       way_q, way_d;
    logic [OWB-1:0]      beat_q, beat_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [SETS-1:0][WAYS-1:0]                         valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0]                         dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-1:0][AW-1:0]                 age_q, age_d;
    logic [SETS-1:0][WAYS-1:0][TW-1:0]                 tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0][LINE_WORDS-1:0][DATA_W-1:0] data_q, data_d;

    // Address split of the latched request
    logic [OWB-1:0] req_off;
    logic [IWB-1:0] req_idx;
    logic [TW-1:0]  req_tag;

    assign req_tag = req_addr_q[ADDR_W-1 -: TW];
    if (OW > 0) begin : g_off
        assign req_off = req_addr_q[OW-1:0];
    end else begin : g_no_off
        assign req_off = '0;
    end
    if (IW > 0) begin : g_idx
        assign req_idx = req_addr_q[OW +: IW];
    end else begin : g_no_idx
        assign req_idx = '0;
    end

    function automatic logic [ADDR_W-1:0] mk_addr(input logic [TW-1:0] t,
                                                  input logic [IWB-1:0] i,
                                                  input logic [OWB-1:0] b);
        return (ADDR_W'(t) << (OW + IW)) | (ADDR_W'(i) << OW) | ADDR_W'(b);
    endfunction

    // Parallel tag compare and victim selection for the addressed set
    logic          hit;
    logic [AW-1:0] hit_way;
    logic          has_inv;
    logic [AW-1:0] victim_inv, victim_lru, victim;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        has_inv    = 1'b0;
        victim_inv = '0;
        victim_lru = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
        end
        // descending scan leaves the lowest-index invalid way
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                has_inv    = 1'b1;
                victim_inv = AW'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[req_idx][w] == AW'(WAYS - 1)) victim_lru = AW'(w);
        end
        victim = has_inv ? victim_inv : victim_lru;
    end

    logic          last_beat;
    logic [AW-1:0] acc_way;
    logic [AW-1:0] acc_age;

    assign last_beat = (beat_q == OWB'(LINE_WORDS - 1));
    assign acc_way   = hit ? hit_way : victim;
    // A way being (re)filled counts as the oldest, so every valid way ages.
    assign acc_age   = hit ? age_q[req_idx][hit_way] : AW'(WAYS - 1);

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_wr_d    = req_wr_q;
        req_wdata_d = req_wdata_q;
        way_d       = way_q;
        beat_d      = beat_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        age_d       = age_q;
        tag_d       = tag_q;
        data_d      = data_q;

        case (state_q)
            S_IDLE: begin
                if (rd_cpu || wr_cpu) begin
                    req_addr_d  = addr_cpu;
                    req_wr_d    = wr_cpu;
                    req_wdata_d = wdata_cpu;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                beat_d = '0;
                way_d  = acc_way;
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == acc_way)
                        age_d[req_idx][w] = '0;
                    else if (age_q[req_idx][w] < acc_age)
                        age_d[req_idx][w] = age_q[req_idx][w] + AW'(1);
                end
                if (hit) begin
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    state_d = S_DONE;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    state_d = (valid_q[req_idx][victim] && dirty_q[req_idx][victim])
                              ? S_WB : S_REFILL;
                end
            end
            S_WB: begin
                if (ready_mem) begin
                    if (last_beat) begin
                        beat_d                  = '0;
                        dirty_d[req_idx][way_q] = 1'b0;
                        state_d                 = S_REFILL;
                    end else begin
                        beat_d = beat_q + OWB'(1);
                    end
                end
            end
            S_REFILL: begin
                if (ready_mem) begin
                    data_d[req_idx][way_q][beat_q] = rdata_mem;
                    if (last_beat) begin
                        beat_d                  = '0;
                        valid_d[req_idx][way_q] = 1'b1;
                        dirty_d[req_idx][way_q] = 1'b0;
                        tag_d[req_idx][way_q]   = req_tag;
                        state_d                 = S_DONE;
                    end else begin
                        beat_d = beat_q + OWB'(1);
                    end
                end
            end
            S_DONE: begin
                ack_d = 1'b1;
                if (req_wr_q) begin
                    data_d[req_idx][way_q][req_off] = req_wdata_q;
                    dirty_d[req_idx][way_q]         = 1'b1;
                end else begin
                    rdata_d = data_q[req_idx][way_q][req_off];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            req_wr_q    <= 1'b0;
            req_wdata_q <= '0;
            way_q       <= '0;
            beat_q      <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            age_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wr_q    <= req_wr_d;
            req_wdata_q <= req_wdata_d;
            way_q       <= way_d;
            beat_q      <= beat_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            age_q       <= age_d;
        end
    end

    // Tag/data storage is qualified by valid, so it needs no reset.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_comb begin
        addr_mem  = '0;
        wdata_mem = '0;
        if (state_q == S_WB) begin
            addr_mem  = mk_addr(tag_q[req_idx][way_q], req_idx, beat_q);
            wdata_mem = data_q[req_idx][way_q][beat_q];
        end else if (state_q == S_REFILL) begin
            addr_mem  = mk_addr(req_tag, req_idx, beat_q);
        end
    end

    assign rd_mem    = (state_q == S_REFILL);
    assign wr_mem    = (state_q == S_WB);
    assign stall_cpu = (state_q != S_IDLE);
    assign ack_cpu   = ack_q;
    assign rdata_cpu = rdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
